// File: rtl/processor_run_monitor.sv
// Run controller and execution-trace capture for the 16-bit core: holds the core in reset,
// runs it to a stop address or cycle budget, then drains the circular trace over valid/ready.
module processor_run_monitor #(
  parameter int PC_W       = 16,
  parameter int INSTR_W    = 16,
  parameter int DATA_W     = 16,
  parameter int RADDR_W    = 3,
  parameter int DEPTH      = 16,
  parameter int CNT_W      = 16,
  parameter int RST_CYCLES = 2
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         arm,
  input  logic [PC_W-1:0]                              stop_pc,
  input  logic [CNT_W-1:0]                             timeout_limit,
  input  logic [PC_W-1:0]                              pc,
  input  logic [INSTR_W-1:0]                           instruction,
  input  logic                                         write_enable,
  input  logic [RADDR_W-1:0]                           write_addr,
  input  logic [DATA_W-1:0]                            alu_result,
  input  logic                                         branch_enable,
  output logic                                         core_reset,
  output logic                                         busy,
  output logic                                         done,
  output logic                                         timed_out,
  output logic                                         overflow,
  output logic [CNT_W-1:0]                             cycle_count,
  output logic [$clog2(DEPTH):0]                       trace_count,
  output logic                                         rd_valid,
  input  logic                                         rd_ready,
  output logic [2+RADDR_W+PC_W+INSTR_W+DATA_W-1:0]     rd_data
);

  localparam int AW      = $clog2(DEPTH);
  localparam int ENTRY_W = 2 + RADDR_W + PC_W + INSTR_W + DATA_W;
  localparam int RCW     = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [AW:0]    FULL_C     = (AW+1)'(DEPTH);
  localparam logic [RCW-1:0] RST_INIT_C = RCW'(RST_CYCLES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RST   = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [RCW-1:0]     rst_cnt_q, rst_cnt_d;
  logic [PC_W-1:0]    stop_pc_q, stop_pc_d;
  logic [CNT_W-1:0]   limit_q, limit_d;
  logic [CNT_W-1:0]   cyc_q, cyc_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]        count_q, count_d;
  logic               done_q, done_d;
  logic               timed_out_q, timed_out_d;
  logic               overflow_q, overflow_d;
  logic               core_reset_q, core_reset_d;
  logic               busy_q, busy_d;
  logic               mem_we_s;
  logic               rd_valid_s;
  logic [CNT_W:0]     cyc_inc_s;
  logic [ENTRY_W-1:0] entry_s;
  logic [ENTRY_W-1:0] mem_q [DEPTH];

  assign entry_s    = {branch_enable, write_enable, write_addr, pc, instruction, alu_result};
  assign cyc_inc_s  = {1'b0, cyc_q} + {{CNT_W{1'b0}}, 1'b1};
  assign rd_valid_s = (state_q == S_DRAIN) && (count_q != {(AW+1){1'b0}});

  // Next-state and datapath control for the run/capture/drain sequence
  always_comb begin
    state_d       = state_q;
    rst_cnt_d     = rst_cnt_q;
    stop_pc_d     = stop_pc_q;
    limit_d       = limit_q;
    cyc_d         = cyc_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    done_d        = done_q;
    timed_out_d   = timed_out_q;
    overflow_d    = overflow_q;
    mem_we_s      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (arm) begin
          state_d     = S_RST;
          rst_cnt_d   = RST_INIT_C;
          stop_pc_d   = stop_pc;
          limit_d     = timeout_limit;
          cyc_d       = {CNT_W{1'b0}};
          wr_ptr_d    = {AW{1'b0}};
          rd_ptr_d    = {AW{1'b0}};
          count_d     = {(AW+1){1'b0}};
          done_d      = 1'b0;
          timed_out_d = 1'b0;
          overflow_d  = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RST: begin
        if (rst_cnt_q == {RCW{1'b0}}) begin
          state_d = S_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q - 1'b1;
        end
      end
      S_RUN: begin
        mem_we_s = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        // A full buffer drops its oldest entry so the newest DEPTH are kept
        if (count_q == FULL_C) begin
          rd_ptr_d   = rd_ptr_q + 1'b1;
          overflow_d = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
        if (cyc_q != {CNT_W{1'b1}}) begin
          cyc_d = cyc_inc_s[CNT_W-1:0];
        end else begin
          cyc_d = cyc_q;
        end
        if (pc == stop_pc_q) begin
          done_d  = 1'b1;
          state_d = S_DRAIN;
        end else if ((limit_q != {CNT_W{1'b0}}) && (cyc_inc_s == {1'b0, limit_q})) begin
          timed_out_d = 1'b1;
          state_d     = S_DRAIN;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        if (rd_valid_s && rd_ready) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          count_d  = count_q - 1'b1;
        end else begin
          count_d = count_q;
        end
        if (count_d == {(AW+1){1'b0}}) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    core_reset_d = (state_d != S_RUN);
    busy_d       = (state_d == S_RST) || (state_d == S_RUN);
  end

  // Control and status registers; reset forces the core back into reset immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      rst_cnt_q    <= {RCW{1'b0}};
      stop_pc_q    <= {PC_W{1'b0}};
      limit_q      <= {CNT_W{1'b0}};
      cyc_q        <= {CNT_W{1'b0}};
      wr_ptr_q     <= {AW{1'b0}};
      rd_ptr_q     <= {AW{1'b0}};
      count_q      <= {(AW+1){1'b0}};
      done_q       <= 1'b0;
      timed_out_q  <= 1'b0;
      overflow_q   <= 1'b0;
      core_reset_q <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      stop_pc_q    <= stop_pc_d;
      limit_q      <= limit_d;
      cyc_q        <= cyc_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      done_q       <= done_d;
      timed_out_q  <= timed_out_d;
      overflow_q   <= overflow_d;
      core_reset_q <= core_reset_d;
      busy_q       <= busy_d;
    end
  end

  // Trace storage; contents are only meaningful below count_q, so no reset is needed
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[wr_ptr_q] <= entry_s;
    end
  end

  assign core_reset  = core_reset_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timed_out   = timed_out_q;
  assign overflow    = overflow_q;
  assign cycle_count = cyc_q;
  assign trace_count = count_q;
  assign rd_valid    = rd_valid_s;
  assign rd_data     = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_processor_run_monitor.sv
// Directed bench: a 16-deep and a 4-deep monitor share the core stimulus; each task checks one scenario.
module tb_processor_run_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        arm = 1'b0;
  logic [15:0] stop_pc = 16'd0;
  logic [15:0] timeout_limit = 16'd0;
  logic [15:0] pc = 16'd0;
  logic [15:0] instruction = 16'd0;
  logic        write_enable = 1'b0;
  logic [2:0]  write_addr = 3'd0;
  logic [15:0] alu_result = 16'd0;
  logic        branch_enable = 1'b0;
  logic        rdy16 = 1'b0;
  logic        rdy4 = 1'b0;

  logic        c16, b16, d16, t16, o16, v16;
  logic [15:0] cc16;
  logic [4:0]  tc16;
  logic [52:0] rd16;
  logic        c4, b4, d4, t4, o4, v4;
  logic [15:0] cc4;
  logic [2:0]  tc4;
  logic [52:0] rd4;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [52:0] got16 [32];
  logic [52:0] got4 [32];
  int          n16 = 0;
  int          n4 = 0;

  always #5 clk = ~clk;

  processor_run_monitor #(.DEPTH(16)) dut16 (
    .clk(clk), .reset(rst_n), .arm(arm), .stop_pc(stop_pc), .timeout_limit(timeout_limit),
    .pc(pc), .instruction(instruction), .write_enable(write_enable), .write_addr(write_addr),
    .alu_result(alu_result), .branch_enable(branch_enable), .core_reset(c16), .busy(b16),
    .done(d16), .timed_out(t16), .overflow(o16), .cycle_count(cc16), .trace_count(tc16),
    .rd_valid(v16), .rd_ready(rdy16), .rd_data(rd16)
  );

  processor_run_monitor #(.DEPTH(4)) dut4 (
    .clk(clk), .reset(rst_n), .arm(arm), .stop_pc(stop_pc), .timeout_limit(timeout_limit),
    .pc(pc), .instruction(instruction), .write_enable(write_enable), .write_addr(write_addr),
    .alu_result(alu_result), .branch_enable(branch_enable), .core_reset(c4), .busy(b4),
    .done(d4), .timed_out(t4), .overflow(o4), .cycle_count(cc4), .trace_count(tc4),
    .rd_valid(v4), .rd_ready(rdy4), .rd_data(rd4)
  );

  function automatic logic [52:0] exp_entry(input logic [15:0] p);
    return {p[1], p[0], p[2:0], p, (16'hA000 | p), (p ^ 16'h5555)};
  endfunction

  // Arms both monitors, then steps the core one pc per cycle while core_reset is low.
  // Returns at the first falling edge after core_reset rises again (monitors in DRAIN).
  task automatic run_core(input logic [15:0] spc, input logic [15:0] lim, input int arm_at,
                          output int lowcnt, output int hicnt);
    logic [15:0] p;
    stop_pc = spc;
    timeout_limit = lim;
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    lowcnt = 0;
    hicnt = 0;
    for (int i = 0; i < 200; i++) begin
      if (!c16) begin
        p = 16'(lowcnt);
        pc = p;
        instruction = 16'hA000 | p;
        alu_result = p ^ 16'h5555;
        write_addr = p[2:0];
        write_enable = p[0];
        branch_enable = p[1];
        if (lowcnt == arm_at) begin
          arm = 1'b1;
          stop_pc = 16'd1;
        end else begin
          arm = 1'b0;
        end
        lowcnt++;
      end else if (lowcnt != 0) begin
        break;
      end else begin
        hicnt++;
      end
      @(negedge clk);
    end
    arm = 1'b0;
  endtask

  task automatic drain16();
    n16 = 0;
    rdy16 = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (!v16) break;
      if (n16 < 32) got16[n16] = rd16;
      n16++;
      @(negedge clk);
    end
    rdy16 = 1'b0;
  endtask

  task automatic drain4();
    n4 = 0;
    rdy4 = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (!v4) break;
      if (n4 < 32) got4[n4] = rd4;
      n4++;
      @(negedge clk);
    end
    rdy4 = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    n_chk++; if (c16 !== 1'b1) begin n_fail++; $display("FAIL reset_core_reset got %b want 1", c16); end
    n_chk++; if (b16 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", b16); end
    n_chk++; if ({d16, t16, o16} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {d16, t16, o16}); end
    n_chk++; if (cc16 !== 16'd0) begin n_fail++; $display("FAIL reset_cycle_count got %0d want 0", cc16); end
    n_chk++; if (tc16 !== 5'd0) begin n_fail++; $display("FAIL reset_trace_count got %0d want 0", tc16); end
    n_chk++; if (v16 !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got %b want 0", v16); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_nominal();
    int lowcnt, hicnt;
    run_core(16'd6, 16'd0, -1, lowcnt, hicnt);
    n_chk++; if (hicnt !== 2) begin n_fail++; $display("FAIL nom_rst_cycles got %0d want 2", hicnt); end
    n_chk++; if (lowcnt !== 7) begin n_fail++; $display("FAIL nom_run_cycles got %0d want 7", lowcnt); end
    n_chk++; if ({d16, t16} !== 2'b10) begin n_fail++; $display("FAIL nom_done_to got %b want 10", {d16, t16}); end
    n_chk++; if (cc16 !== 16'd7) begin n_fail++; $display("FAIL nom_cycle_count got %0d want 7", cc16); end
    n_chk++; if (tc16 !== 5'd7) begin n_fail++; $display("FAIL nom_trace_count got %0d want 7", tc16); end
    n_chk++; if ({v16, b16} !== 2'b10) begin n_fail++; $display("FAIL nom_drain_valid_busy got %b want 10", {v16, b16}); end
    n_chk++; if (o4 !== 1'b1) begin n_fail++; $display("FAIL nom_small_overflow got %b want 1", o4); end
    drain16();
    n_chk++; if (n16 !== 7) begin n_fail++; $display("FAIL nom_drain_count got %0d want 7", n16); end
    for (int i = 0; i < 7; i++) begin
      n_chk++;
      if (got16[i] !== exp_entry(16'(i))) begin
        n_fail++; $display("FAIL nom_entry%0d got %h want %h", i, got16[i], exp_entry(16'(i)));
      end
    end
    n_chk++; if ({v16, b16, tc16} !== 7'd0) begin n_fail++; $display("FAIL nom_idle_after got %b want 0", {v16, b16, tc16}); end
    n_chk++; if (d16 !== 1'b1) begin n_fail++; $display("FAIL nom_done_sticky got %b want 1", d16); end
    drain4();
    n_chk++; if (n4 !== 4) begin n_fail++; $display("FAIL nom_small_count got %0d want 4", n4); end
    n_chk++; if (got4[0][47:32] !== 16'd3) begin n_fail++; $display("FAIL nom_small_first got %0d want 3", got4[0][47:32]); end
  endtask

  task automatic test_timeout();
    int lowcnt, hicnt;
    run_core(16'hFFFF, 16'd5, -1, lowcnt, hicnt);
    n_chk++; if (lowcnt !== 5) begin n_fail++; $display("FAIL to_run_cycles got %0d want 5", lowcnt); end
    n_chk++; if ({d16, t16} !== 2'b01) begin n_fail++; $display("FAIL to_done_to got %b want 01", {d16, t16}); end
    n_chk++; if (cc16 !== 16'd5) begin n_fail++; $display("FAIL to_cycle_count got %0d want 5", cc16); end
    n_chk++; if (tc16 !== 5'd5) begin n_fail++; $display("FAIL to_trace_count got %0d want 5", tc16); end
    n_chk++; if (tc4 !== 3'd4) begin n_fail++; $display("FAIL to_small_trace_count got %0d want 4", tc4); end
    drain16();
    drain4();
    n_chk++; if (n16 !== 5) begin n_fail++; $display("FAIL to_drain_count got %0d want 5", n16); end
  endtask

  task automatic test_overflow();
    int lowcnt, hicnt;
    run_core(16'd9, 16'd0, -1, lowcnt, hicnt);
    n_chk++; if (o4 !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b want 1", o4); end
    n_chk++; if (tc4 !== 3'd4) begin n_fail++; $display("FAIL ovf_trace_count got %0d want 4", tc4); end
    n_chk++; if ({o16, tc16} !== {1'b0, 5'd10}) begin n_fail++; $display("FAIL ovf_big got %b want 001010", {o16, tc16}); end
    drain4();
    drain16();
    n_chk++; if (n4 !== 4) begin n_fail++; $display("FAIL ovf_drain_count got %0d want 4", n4); end
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (got4[i] !== exp_entry(16'(i + 6))) begin
        n_fail++; $display("FAIL ovf_entry%0d got pc %0d want %0d", i, got4[i][47:32], i + 6);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lowcnt, hicnt;
    logic        held;
    logic [52:0] held_val;
    run_core(16'd3, 16'd0, -1, lowcnt, hicnt);
    held = 1'b0;
    held_val = 53'd0;
    n16 = 0;
    for (int i = 0; i < 40; i++) begin
      rdy16 = ((i % 4) == 0) || ((i % 4) == 3);
      if (!v16) break;
      if (held) begin
        n_chk++;
        if (rd16 !== held_val) begin n_fail++; $display("FAIL bp_hold cyc%0d got %h want %h", i, rd16, held_val); end
      end
      if (rdy16) begin
        if (n16 < 32) got16[n16] = rd16;
        n16++;
      end
      held = !rdy16;
      held_val = rd16;
      @(negedge clk);
    end
    rdy16 = 1'b0;
    n_chk++; if (n16 !== 4) begin n_fail++; $display("FAIL bp_count got %0d want 4", n16); end
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (got16[i] !== exp_entry(16'(i))) begin
        n_fail++; $display("FAIL bp_entry%0d got pc %0d want %0d", i, got16[i][47:32], i);
      end
    end
    drain4();
  endtask

  task automatic test_stop_and_timeout();
    int lowcnt, hicnt;
    run_core(16'd3, 16'd4, -1, lowcnt, hicnt);
    n_chk++; if ({d16, t16} !== 2'b10) begin n_fail++; $display("FAIL both_done_to got %b want 10", {d16, t16}); end
    n_chk++; if (cc16 !== 16'd4) begin n_fail++; $display("FAIL both_cycle_count got %0d want 4", cc16); end
    drain16();
    drain4();
  endtask

  task automatic test_arm_ignored();
    int lowcnt, hicnt;
    run_core(16'd4, 16'd0, 2, lowcnt, hicnt);
    n_chk++; if (lowcnt !== 5) begin n_fail++; $display("FAIL armign_run_cycles got %0d want 5", lowcnt); end
    n_chk++; if ({d16, cc16} !== {1'b1, 16'd5}) begin n_fail++; $display("FAIL armign_state got %0d/%0d want 1/5", d16, cc16); end
    drain16();
    drain4();
    n_chk++; if (n16 !== 5) begin n_fail++; $display("FAIL armign_drain_count got %0d want 5", n16); end
  endtask

  task automatic test_reset_midrun();
    stop_pc = 16'd100;
    timeout_limit = 16'd0;
    pc = 16'd0;
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!c16) break;
      @(negedge clk);
    end
    n_chk++; if (c16 !== 1'b0) begin n_fail++; $display("FAIL mid_reached_run got %b want 0", c16); end
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_chk++; if (c16 !== 1'b1) begin n_fail++; $display("FAIL mid_async_core_reset got %b want 1", c16); end
    n_chk++; if (b16 !== 1'b0) begin n_fail++; $display("FAIL mid_async_busy got %b want 0", b16); end
    n_chk++; if ({cc16, tc16} !== 21'd0) begin n_fail++; $display("FAIL mid_async_counts got %0d/%0d want 0/0", cc16, tc16); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++; if ({v16, b16, c16} !== 3'b001) begin n_fail++; $display("FAIL mid_idle_after got %b want 001", {v16, b16, c16}); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_timeout();
    test_overflow();
    test_back_to_back();
    test_stop_and_timeout();
    test_arm_ignored();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/processor_run_monitor.md
# processor_run_monitor

Parametrised run controller and execution-trace capture unit for the 16-bit processor. It holds the core in reset, releases it on `arm`, and records one trace entry per clock into a circular buffer. It stops the core when the PC hits a programmable stop address or a cycle budget expires, then streams the captured trace out through a valid/ready port. It replaces open-loop "run until PC == N" control with a reusable, self-terminating block that is synthesizable and bench-usable.

## Interface
- `PC_W`, 16: width of `pc` and `stop_pc`.
- `INSTR_W`, 16: width of `instruction`.
- `DATA_W`, 16: width of `alu_result`.
- `RADDR_W`, 3: width of `write_addr` (register index).
- `DEPTH`, 16: trace entries; power of two, ≥2.
- `CNT_W`, 16: width of `cycle_count` and `timeout_limit`.
- `RST_CYCLES`, 2: cycles `core_reset` is held after `arm`; ≥1.
- `clk`  in  1  single clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `arm`  in  1  start pulse; honoured only in IDLE.
- `stop_pc`  in  PC_W  completion address; sampled on `arm`.
- `timeout_limit`  in  CNT_W  RUN-cycle budget, 0 = unlimited; sampled on `arm`.
- `pc`  in  PC_W  core program counter.
- `instruction`  in  INSTR_W  current instruction.
- `write_enable`  in  1  core register-file write strobe.
- `write_addr`  in  RADDR_W  core write register index.
- `alu_result`  in  DATA_W  core ALU output.
- `branch_enable`  in  1  core BEQ taken.
- `core_reset`  out  1  active-high reset to the processor.
- `busy`  out  1  state is RST or RUN.
- `done`  out  1  sticky, stop_pc reached; cleared on accepted `arm`.
- `timed_out`  out  1  sticky, budget expired; cleared on accepted `arm`.
- `overflow`  out  1  sticky, oldest entries overwritten; cleared on accepted `arm`.
- `cycle_count`  out  CNT_W  RUN cycles elapsed, saturating at all-ones.
- `trace_count`  out  clog2(DEPTH)+1  entries held.
- `rd_valid`  out  1  oldest entry presented.
- `rd_ready`  in  1  consumer accepts entry.
- `rd_data`  out  2+RADDR_W+PC_W+INSTR_W+DATA_W  entry: {branch_enable, write_enable, write_addr, pc, instruction, alu_result}, MSB first.

## Operation
- States: IDLE, RST, RUN, DRAIN.
- Reset values: state IDLE, `core_reset`=1, every other output 0, pointers 0.
- IDLE: `core_reset`=1. An accepted `arm` latches `stop_pc` and `timeout_limit`, clears buffer, counters and sticky flags, and moves to RST.
- RST: `core_reset`=1 for exactly RST_CYCLES cycles, then RUN.
- RUN: `core_reset`=0. Each cycle writes the input tuple at `wr_ptr`, increments `wr_ptr` mod DEPTH, and increments `cycle_count`.
  - Buffer full: the write overwrites the oldest entry, advances `rd_ptr`, sets `overflow`, and leaves `trace_count`=DEPTH.
  - `pc`==latched `stop_pc`: that cycle's entry is recorded, `done`=1, go to DRAIN.
  - Otherwise, if `timeout_limit`≠0 and `cycle_count`+1==`timeout_limit`: entry recorded, `timed_out`=1, go to DRAIN.
  - Stop and timeout in the same cycle: stop wins, `timed_out` stays 0.
- DRAIN: `core_reset`=1 (core frozen). `rd_valid`=(`trace_count`≠0). A pop occurs when `rd_valid`&&`rd_ready`. When `trace_count` is 0, go to IDLE; the sticky flags hold.
- `arm` is ignored in RST, RUN and DRAIN.
- `rd_valid`=0 outside DRAIN; `rd_ready` is ignored there.
- Asserting `reset` in any state aborts immediately. State is lost, and `core_reset` goes to 1 asynchronously.

## Timing
- `arm` high at edge k: state RST and `busy`=1 after k. `core_reset` falls after edge k+RST_CYCLES.
- The first trace entry is captured at edge k+RST_CYCLES+1 and holds the core's first post-reset `pc`.
- Stop or timeout detected at edge m: state DRAIN and `core_reset`=1 after m. `rd_valid` is high in the same cycle.
- `rd_data` is combinational from the storage at `rd_ptr`, so there is zero read latency. One pop per cycle is possible with `rd_ready` held high.
- `rd_data` must stay stable while `rd_valid`&&!`rd_ready`.
- The cycle after the final pop: `rd_valid`=0, state IDLE.
- `busy`, `done`, `timed_out`, `overflow` and `cycle_count` are registered outputs.

## Test plan
- **Nominal run.** Defaults, `stop_pc`=6, `timeout_limit`=0, core stepping pc 0..6.
  - Required: `core_reset` low for 7 cycles; `done`=1, `timed_out`=0, `cycle_count`=7.
  - Drain with `rd_ready`=1 yields 7 entries with pc 0..6 in order, then state IDLE.
- **Timeout.** `stop_pc`=0xFFFF, `timeout_limit`=5.
  - Required: `timed_out`=1, `done`=0, `cycle_count`=5, `trace_count`=5.
- **Overflow.** DEPTH=4, `stop_pc`=9, pc 0..9.
  - Required: `overflow`=1, and the drained pcs are 6,7,8,9.
- **Backpressure.** Toggle `rd_ready` 1,0,0,1 during drain.
  - Required: `rd_data` is held while not ready, and no entry is lost or duplicated.
- **Simultaneous stop and timeout.** `stop_pc`=3 with `timeout_limit`=4, pc 0..3.
  - Required: `done`=1, `timed_out`=0.
- **Reset and arm corner cases.**
  - Asserting `reset` mid-RUN forces `core_reset`=1 and `busy`=0 without waiting for a clock edge.
  - `arm` pulsed during RUN has no effect.
